spin_dac_feeder: RTL
====================

Name: spin_dac_feeder

Overview:
Transmit-side sample feeder for the AD9361 interface core, running in the interface clock domain (l_clk). It buffers DATA_WIDTH-bit I/Q sample pairs from the processing side in a small FIFO, prefills, then returns one pair per core dac_valid strobe. Each pair is presented MSB-aligned on the core's 16-bit dac_data_i0/q0 inputs. Underruns are reported on dac_dunf and counted.

Parameters:
DATA_WIDTH, 12, sample width per rail; legal range 1..16.
ADDR_WIDTH, 4, FIFO address bits; depth DEPTH = 2**ADDR_WIDTH = 16.
PREFILL_LEVEL, 8, entries required before streaming starts; legal range 1..DEPTH.

Ports:
l_clk  input  1  interface clock.
rst  input  1  reset.
tx_start  input  1  level; 1 = run the transmit path, 0 = stop and flush.
wr_valid  input  1  write-side sample pair valid.
wr_ready  output  1  FIFO not full.
re_data_in  input  DATA_WIDTH  I sample, two's complement.
im_data_in  input  DATA_WIDTH  Q sample, two's complement.
dac_enable_i0  input  1  channel enable from core.
dac_valid_i0  input  1  core sample request strobe; serves both I and Q rails.
dac_data_i0  output  16  I sample to core.
dac_data_q0  output  16  Q sample to core.
dac_dunf  output  1  one-cycle underflow pulse.
fifo_level  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
underrun_count  output  16  saturating underrun counter.
streaming  output  1  high in STREAM state.

Behaviour:
- Clock and reset: single clock l_clk; rst is asynchronous, active-high.
- Reset values: every output is 0, with one exception: wr_ready is 1 once rst deasserts. State is IDLE, the FIFO is empty and the read/write pointers are 0.
- run = tx_start & dac_enable_i0.
- FIFO write: a write occurs when wr_valid & wr_ready. wr_ready = (fifo_level != DEPTH).
- FIFO read: a pop occurs only in STREAM, when dac_valid_i0 is high and the FIFO is not empty.
- Pointers wrap modulo DEPTH.
- Simultaneous push and pop: fifo_level is unchanged. This is legal when full (pop frees the slot) and when empty (no pop possible, so the push only increments the level).
- Data alignment: dac_data_i0 = {sample, (16-DATA_WIDTH) zeros}; dac_data_q0 likewise. Registered outputs.
- Latency: the sample popped on a dac_valid_i0 cycle is visible from the next l_clk edge. It holds until the next dac_valid_i0.
- Output gating: in non-STREAM states, dac_data is driven to 0 on each dac_valid_i0.
- State IDLE:
  - Writes are accepted.
  - run=1 moves to PREFILL on the next cycle.
- State PREFILL:
  - Outputs 0.
  - When fifo_level >= PREFILL_LEVEL, moves to STREAM; streaming rises on that same transition edge.
- State STREAM:
  - Each dac_valid_i0 with a non-empty FIFO pops one pair.
  - dac_valid_i0 with an empty FIFO forces data to 0, pulses dac_dunf for 1 cycle and increments underrun_count (saturating at 0xFFFF). It then moves to UNDERRUN.
- State UNDERRUN:
  - One cycle, outputs 0, then moves to PREFILL.
  - Re-prefill is required before streaming resumes.
- run=0 in any non-IDLE state:
  - Moves to IDLE next cycle.
  - The FIFO is flushed (pointers and level to 0) on that same edge.
  - dac_data is driven to 0.
  - underrun_count is not cleared; only rst clears it.
  - A write coinciding with the flush edge is discarded.
- Reset mid-stream: everything returns immediately to the reset values.

Optional Feature:
- Macro: SPIN_DAC_TONE_EN.
- With the macro: adds input port tone_en (1 bit).
  - While tone_en=1 and state is STREAM or PREFILL, the FIFO is bypassed.
  - A DATA_WIDTH-bit ramp counter increments on each dac_valid_i0.
  - Outputs: I = ramp and Q = ~ramp, both MSB-aligned.
  - No pops, no dac_dunf; the prefill condition is ignored, so PREFILL goes to STREAM next cycle.
  - The ramp resets to 0 in IDLE and on rst.
- Without the macro: no tone_en port and no ramp logic.

Test Plan:
- Reset and fill: assert rst; then write 16 pairs (re = 0x001..0x010) with tx_start=0. Required: wr_ready drops after the 16th write, fifo_level=16, dac_data stays 0.
- Normal stream: tx_start=1, dac_enable_i0=1, dac_valid_i0 every 4 cycles after 8 pairs are loaded. Required: streaming rises; dac_data_i0 = 0x0010, 0x0020, ... each one cycle after its valid; no dac_dunf.
- Underrun: load 8 pairs, stream 9 valids. Required: the 9th valid gives dac_data_i0=0, a single-cycle dac_dunf, underrun_count=1, then PREFILL. Streaming resumes only after 8 more writes.
- Simultaneous full push and pop: with the FIFO full in STREAM, wr_valid and dac_valid_i0 in the same cycle. Required: fifo_level stays 16, the new pair is stored and order is preserved.
- Stop mid-stream: drop tx_start with 5 entries queued. Required: IDLE next cycle, fifo_level=0, dac_data=0, underrun_count retained.
- Tone (SPIN_DAC_TONE_EN): tone_en=1, run=1, empty FIFO, 3 valids. Required: dac_data_i0 = 0x0000, 0x0010, 0x0020; dac_data_q0 = 0xFFF0, 0xFFE0, 0xFFD0; no dac_dunf.

Source files
------------

// File: rtl/spin_dac_feeder.sv
// Transmit sample feeder: buffers I/Q pairs, prefills, then hands one MSB-aligned pair to the
// AD9361 core per dac_valid_i0 strobe. Define SPIN_DAC_TONE_EN to add the tone_en ramp generator.
module spin_dac_feeder #(
    parameter int DATA_WIDTH    = 12,
    parameter int ADDR_WIDTH    = 4,
    parameter int PREFILL_LEVEL = 8
) (
    input  logic                         l_clk,
    input  logic                         rst,
    input  logic                         tx_start,
    input  logic                         wr_valid,
    output logic                         wr_ready,
    input  logic signed [DATA_WIDTH-1:0] re_data_in,
    input  logic signed [DATA_WIDTH-1:0] im_data_in,
    input  logic                         dac_enable_i0,
    input  logic                         dac_valid_i0,
`ifdef SPIN_DAC_TONE_EN
    input  logic                         tone_en,
`endif
    output logic [15:0]                  dac_data_i0,
    output logic [15:0]                  dac_data_q0,
    output logic                         dac_dunf,
    output logic [ADDR_WIDTH:0]          fifo_level,
    output logic [15:0]                  underrun_count,
    output logic                         streaming
);

    localparam int                  DEPTH    = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] FULL_LVL = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] PRE_LVL  = (ADDR_WIDTH + 1)'(PREFILL_LEVEL);
    localparam logic [ADDR_WIDTH:0] LVL_ONE  = (ADDR_WIDTH + 1)'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PREFILL,
        S_STREAM,
        S_UNDERRUN
    } state_t;

    state_t state, state_nxt;

    logic signed [DATA_WIDTH-1:0] mem_re [DEPTH];
    logic signed [DATA_WIDTH-1:0] mem_im [DEPTH];
    logic [ADDR_WIDTH-1:0]        wr_ptr, rd_ptr;
    logic [ADDR_WIDTH:0]          level;

    logic run, flush, push, pop, underrun, tone_act;
    logic [15:0] data_i_p1, data_q_p1;
    logic        dunf_p1;
    logic [15:0] unf_cnt;

    function automatic logic [15:0] align_msb(input logic [DATA_WIDTH-1:0] s);
        logic [15:0] r;
        r = '0;
        r[15 -: DATA_WIDTH] = s;
        return r;
    endfunction

    // Stage p0: request decode and FIFO bookkeeping
    assign run      = tx_start & dac_enable_i0;
    assign flush    = ~run & (state != S_IDLE);
    assign wr_ready = ~rst & (level != FULL_LVL);
    assign pop      = (state == S_STREAM) & run & dac_valid_i0 & (level != '0) & ~tone_act;
    assign underrun = (state == S_STREAM) & run & dac_valid_i0 & (level == '0) & ~tone_act;
    // A full FIFO still takes a write when the same cycle frees a slot.
    assign push     = wr_valid & (wr_ready | pop) & ~flush;

`ifdef SPIN_DAC_TONE_EN
    logic [DATA_WIDTH-1:0] ramp_p0;

    assign tone_act = tone_en & run & ((state == S_STREAM) | (state == S_PREFILL));

    always_ff @(posedge l_clk or posedge rst) begin
        if (rst) begin
            ramp_p0 <= '0;
        end else if (state == S_IDLE) begin
            ramp_p0 <= '0;
        end else if (tone_act && dac_valid_i0) begin
            ramp_p0 <= ramp_p0 + DATA_WIDTH'(1);
        end
    end
`else
    assign tone_act = 1'b0;
`endif

    always_ff @(posedge l_clk) begin
        if (push) begin
            mem_re[wr_ptr] <= re_data_in;
            mem_im[wr_ptr] <= im_data_in;
        end
    end

    always_ff @(posedge l_clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            if (push && !pop)      level <= level + LVL_ONE;
            else if (pop && !push) level <= level - LVL_ONE;
        end
    end

    always_ff @(posedge l_clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (run) state_nxt = S_PREFILL;
            end
            S_PREFILL: begin
                if (!run)                             state_nxt = S_IDLE;
                else if (tone_act || level >= PRE_LVL) state_nxt = S_STREAM;
            end
            S_STREAM: begin
                if (!run)          state_nxt = S_IDLE;
                else if (underrun) state_nxt = S_UNDERRUN;
            end
            S_UNDERRUN: begin
                state_nxt = run ? S_PREFILL : S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Stage p1: registered outputs to the core
    always_ff @(posedge l_clk or posedge rst) begin
        if (rst) begin
            data_i_p1 <= '0;
            data_q_p1 <= '0;
            dunf_p1   <= 1'b0;
            unf_cnt   <= '0;
        end else begin
            dunf_p1 <= underrun;
            if (underrun && unf_cnt != 16'hFFFF) unf_cnt <= unf_cnt + 16'd1;
            if (flush) begin
                data_i_p1 <= '0;
                data_q_p1 <= '0;
            end else if (dac_valid_i0) begin
`ifdef SPIN_DAC_TONE_EN
                if (tone_act) begin
                    data_i_p1 <= align_msb(ramp_p0);
                    data_q_p1 <= align_msb(~ramp_p0);
                end else
`endif
                if (pop) begin
                    data_i_p1 <= align_msb(mem_re[rd_ptr]);
                    data_q_p1 <= align_msb(mem_im[rd_ptr]);
                end else begin
                    data_i_p1 <= '0;
                    data_q_p1 <= '0;
                end
            end
        end
    end

    assign dac_data_i0    = data_i_p1;
    assign dac_data_q0    = data_q_p1;
    assign dac_dunf       = dunf_p1;
    assign fifo_level     = level;
    assign underrun_count = unf_cnt;
    assign streaming      = (state == S_STREAM);

endmodule
